// File: rtl/seq_signed_divider.sv
`default_nettype none
// ============================================================================
// seq_signed_divider : radix-2 restoring signed divider (quotient toward zero)
// Rev 1.0
// ============================================================================
module seq_signed_divider #(
  parameter int DW = 15,
  parameter int VW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero,
  output logic          overflow
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [VW-1:0] rem;
  logic [DW-1:0] quo;      // dividend magnitude shifts out as quotient bits shift in
  logic [VW-1:0] dmag;
  logic [VW-1:0] div_low;
  logic          sign_n;
  logic          sign_d;
  logic          zero_d;
  logic          ovf_d;

  logic [VW:0]   shifted;
  logic [VW:0]   diff;
  logic          ge;

  always_comb begin
    shifted = {rem, quo[DW-1]};
    diff    = shifted - {1'b0, dmag};
    ge      = (shifted >= {1'b0, dmag});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      count       <= '0;
      rem         <= '0;
      quo         <= '0;
      dmag        <= '0;
      div_low     <= '0;
      sign_n      <= 1'b0;
      sign_d      <= 1'b0;
      zero_d      <= 1'b0;
      ovf_d       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            sign_n   <= dividend[DW-1];
            sign_d   <= divisor[VW-1];
            quo      <= dividend[DW-1] ? -dividend : dividend;
            dmag     <= divisor[VW-1] ? -divisor : divisor;
            div_low  <= dividend[VW-1:0];
            rem      <= '0;
            count    <= CW'(DW-1);
            zero_d   <= (divisor == '0);
            ovf_d    <= (dividend == {1'b1, {(DW-1){1'b0}}}) && (divisor == '1);
            state    <= (divisor == '0) ? FIX : CALC;
          end
        end
        CALC: begin
          rem <= ge ? diff[VW-1:0] : shifted[VW-1:0];
          quo <= {quo[DW-2:0], ge};
          if (count == '0) state <= FIX;
          else             count <= count - CW'(1);
        end
        FIX: begin
          if (zero_d) begin
            quotient  <= '1;
            remainder <= div_low;
          end else begin
            quotient  <= (sign_n ^ sign_d) ? -quo : quo;
            remainder <= sign_n ? -rem : rem;
          end
          div_by_zero <= zero_d;
          overflow    <= ovf_d;
          state       <= DONE;
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_signed_divider.sv
`default_nettype none
// Directed and randomized checks of seq_signed_divider against hand values and a truncating model.
module tb_seq_signed_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [14:0] dividend = '0;
  logic [6:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [14:0] quotient;
  logic [6:0]  remainder;
  logic        div_by_zero;
  logic        overflow;

  int total = 0;
  int bad = 0;

  seq_signed_divider #(.DW(15), .VW(7)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One operation: accept, wait for result, check, hold for 'stall' cycles, then release.
  task automatic do_op(input logic [14:0] a, input logic [6:0] b,
                       input logic [14:0] eq, input logic [6:0] er,
                       input logic edz, input logic eov,
                       input int elat, input int stall, input logic poke);
    int n;
    int qv;
    int rv;
    n = 0;
    while (!in_ready && n < 50) begin cycle(); n++; end
    check("accept_ready", {31'd0, in_ready}, 32'd1);
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 60) begin
      if (poke && n == 5) begin
        dividend = 15'd1;
        divisor  = 7'd1;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      cycle();
      n++;
    end
    in_valid = 1'b0;
    check("latency", n, elat);
    check("quotient", {17'd0, quotient}, {17'd0, eq});
    check("remainder", {25'd0, remainder}, {25'd0, er});
    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, edz});
    check("overflow", {31'd0, overflow}, {31'd0, eov});
    if (!edz && !eov) begin
      qv = $signed(quotient);
      rv = $signed(remainder);
      check("invariant", qv * $signed(b) + rv, $signed(a));
    end
    for (int i = 0; i < stall; i++) begin
      cycle();
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_ready", {31'd0, in_ready}, 32'd0);
      check("hold_quot", {17'd0, quotient}, {17'd0, eq});
      check("hold_rem", {25'd0, remainder}, {25'd0, er});
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check("release_valid", {31'd0, out_valid}, 32'd0);
    check("release_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic rand_op(input logic [14:0] a, input logic [6:0] b, input int stall);
    int ai;
    int bi;
    int qi;
    int ri;
    logic [14:0] eq;
    logic [6:0]  er;
    ai = $signed(a);
    bi = $signed(b);
    if (bi == 0) begin
      do_op(a, b, 15'h7FFF, a[6:0], 1'b1, 1'b0, 2, stall, 1'b0);
    end else begin
      qi = ai / bi;
      ri = ai % bi;
      eq = qi[14:0];
      er = ri[6:0];
      do_op(a, b, eq, er, 1'b0, (ai == -16384 && bi == -1), 17, stall, 1'b0);
    end
  endtask

  initial begin
    // reset state
    repeat (3) cycle();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_quotient", {17'd0, quotient}, 32'd0);
    check("rst_remainder", {25'd0, remainder}, 32'd0);
    check("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    rst = 1'b0;
    cycle();
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // sign combinations
    do_op(15'd100,     7'd7,      15'd14,       7'd2,       1'b0, 1'b0, 17, 0, 1'b0);
    do_op(15'(-100),   7'd7,      15'(-14),     7'(-2),     1'b0, 1'b0, 17, 0, 1'b0);
    do_op(15'd100,     7'(-7),    15'(-14),     7'd2,       1'b0, 1'b0, 17, 0, 1'b0);
    do_op(15'(-100),   7'(-7),    15'd14,       7'(-2),     1'b0, 1'b0, 17, 0, 1'b0);

    // extremes
    do_op(15'd4096,    7'(-64),   15'(-64),     7'd0,       1'b0, 1'b0, 17, 0, 1'b0);
    do_op(15'(-16383), 7'd63,     15'(-260),    7'(-3),     1'b0, 1'b0, 17, 0, 1'b0);
    do_op(15'd16383,   7'(-64),   15'(-255),    7'd63,      1'b0, 1'b0, 17, 0, 1'b0);

    // boundaries
    do_op(15'h4000,    7'h7F,     15'h4000,     7'd0,       1'b0, 1'b1, 17, 0, 1'b0);
    do_op(15'd5,       7'd0,      15'h7FFF,     7'd5,       1'b1, 1'b0, 2,  0, 1'b0);
    do_op(15'd0,       7'(-3),    15'd0,        7'd0,       1'b0, 1'b0, 17, 0, 1'b0);

    // backpressure with an ignored in_valid pulse during CALC
    do_op(15'(-100),   7'd7,      15'(-14),     7'(-2),     1'b0, 1'b0, 17, 10, 1'b1);

    // reset in the middle of CALC
    dividend = 15'd100;
    divisor  = 7'd7;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (8) cycle();
    rst = 1'b1;
    cycle();
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_quotient", {17'd0, quotient}, 32'd0);
    check("midrst_remainder", {25'd0, remainder}, 32'd0);
    check("midrst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("midrst_no_valid", {31'd0, out_valid}, 32'd0);
    end
    do_op(15'd100,     7'd7,      15'd14,       7'd2,       1'b0, 1'b0, 17, 0, 1'b0);

    // randomized operands with random stalls
    rand_op(15'h4000, 7'h40, 1);
    rand_op(15'h3FFF, 7'h7F, 0);
    for (int k = 0; k < 300; k++) begin
      rand_op(15'($urandom), 7'($urandom), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
